vram_arbiter: RTL
=================

# vram_arbiter

Shares the single read/write port (port A) of the 16 KB VDP video RAM between the renderer fetch path and the CPU access path. The block grants at most one access per clock and returns read data one cycle later, tagged to the requester that issued it. It sits between the VDP register/CPU interface, the renderer, and the VRAM macro. Port B of the VRAM (display read-only) is not touched by this block.

## Interface
- CPU_MAX_WAIT, 8, cycles a pending CPU request may be refused before it is forced ahead of the renderer (1..15)
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- r_req  in  1  renderer read request, held until r_gnt
- r_addr  in  14  renderer read address, stable while r_req
- r_gnt  out  1  renderer access issued this cycle
- r_rvalid  out  1  r_rdata valid
- r_rdata  out  8  renderer read data
- c_req  in  1  CPU request, held until c_gnt
- c_we  in  1  1 = write, 0 = read, stable while c_req
- c_addr  in  14  CPU address, stable while c_req
- c_wdata  in  8  CPU write data
- c_gnt  out  1  CPU access issued this cycle
- c_rvalid  out  1  c_rdata valid (reads only)
- c_rdata  out  8  CPU read data
- ram_we  out  1  to VRAM port A write enable
- ram_addr  out  14  to VRAM port A address
- ram_din  out  8  to VRAM port A write data
- ram_dout  in  8  from VRAM port A, registered read (1-cycle latency, read-old-on-write)

## Operation
- Grant decision is combinational within the cycle; exactly one of r_gnt/c_gnt, or neither.
- Priority: renderer over CPU, except when wait_cnt == CPU_MAX_WAIT and c_req=1, then CPU wins and renderer is refused (r_req held, retried next cycle).
- wait_cnt (4 bit): increments when c_req=1 and c_gnt=0, saturates at CPU_MAX_WAIT; clears to 0 on c_gnt or c_req=0.
- Granted access drives ram_addr from the winner; ram_we = c_gnt & c_we; ram_din = c_wdata. No grant: ram_we=0, ram_addr=0, ram_din=0.
- Return tag register owner ∈ {NONE, REND, CPU_RD}: loaded each cycle with REND if r_gnt, CPU_RD if c_gnt & !c_we, else NONE.
- Cycle after a read grant: matching rvalid=1 for exactly one cycle; its rdata = ram_dout. CPU writes produce no rvalid.
- r_rdata/c_rdata hold their last valid value while rvalid=0.
- Same-address write then read in consecutive cycles: read returns new data. Renderer read in the same cycle as a CPU write cannot occur (one grant per cycle).

## Timing
- Reset: r_gnt=c_gnt=0, r_rvalid=c_rvalid=0, r_rdata=c_rdata=0, ram_we=0, ram_addr=0, ram_din=0, wait_cnt=0, owner=NONE. While reset=1 no grant is issued.
- Reset asserted the cycle after a read grant: rvalid suppressed, data dropped; requester must re-request.
- Read latency: grant in cycle N, rvalid in N+1. Back-to-back grants give one rvalid per cycle.
- Write: committed at the edge ending the grant cycle.
- Worst-case CPU latency with continuous r_req: CPU_MAX_WAIT+1 cycles from c_req to c_gnt.
- Requester may deassert req the cycle after gnt or keep it high for the next access (new access each granted cycle).

## Structure
- Package vram_pkg: VRAM_AW=14, VRAM_DW=8, owner_t enum {OWN_NONE, OWN_REND, OWN_CPU}.
- Sub-module vram_starve_ctr (saturating wait counter, inputs inc/clr, output at_max); grant logic, owner tag and data return stay in vram_arbiter.
- VRAM macro is instantiated by the parent, not inside this block.

## Test plan
- Reset release, preload VRAM[0x0100]=0x5A; r_req addr 0x0100 -> r_gnt cycle N, r_rvalid N+1 with r_rdata=0x5A, c_rvalid stays 0.
- CPU write 0x3FFF<=0xA5 then CPU read 0x3FFF next cycle -> ram_we 1 cycle, c_rvalid with c_rdata=0xA5, no r_rvalid.
- r_req held continuously, c_req read at cycle 0, CPU_MAX_WAIT=8 -> c_gnt at cycle 8, r_gnt low that cycle only, wait_cnt back to 0.
- Both requests, wait_cnt<max -> renderer served, CPU refused; drop c_req for one cycle -> wait_cnt clears.
- Alternating r/c reads every cycle -> rvalid pulses route to correct requester in issue order, no cross-delivery.
- Reset asserted the cycle after a CPU read grant -> c_rvalid stays 0, all outputs at reset values next cycle.

Source files
------------

// File: rtl/vram_pkg.sv
// Shared widths and the return-tag type for the VRAM port A arbiter.
package vram_pkg;
  localparam int VRAM_AW = 14;
  localparam int VRAM_DW = 8;
  localparam int WAIT_W  = 4;

  typedef enum logic [1:0] {OWN_NONE, OWN_REND, OWN_CPU} owner_t;
endpackage

// File: rtl/vram_arbiter_if.sv
// Renderer, CPU and VRAM port A signals. The arbiter takes the slave view;
// the parent (requesters plus the VRAM macro) takes the master view.
interface vram_arbiter_if;
  import vram_pkg::*;

  logic               r_req;
  logic [VRAM_AW-1:0] r_addr;
  logic               r_gnt;
  logic               r_rvalid;
  logic [VRAM_DW-1:0] r_rdata;

  logic               c_req;
  logic               c_we;
  logic [VRAM_AW-1:0] c_addr;
  logic [VRAM_DW-1:0] c_wdata;
  logic               c_gnt;
  logic               c_rvalid;
  logic [VRAM_DW-1:0] c_rdata;

  logic               ram_we;
  logic [VRAM_AW-1:0] ram_addr;
  logic [VRAM_DW-1:0] ram_din;
  logic [VRAM_DW-1:0] ram_dout;

  modport slave (
    input  r_req, r_addr, c_req, c_we, c_addr, c_wdata, ram_dout,
    output r_gnt, r_rvalid, r_rdata, c_gnt, c_rvalid, c_rdata,
           ram_we, ram_addr, ram_din
  );

  modport master (
    output r_req, r_addr, c_req, c_we, c_addr, c_wdata, ram_dout,
    input  r_gnt, r_rvalid, r_rdata, c_gnt, c_rvalid, c_rdata,
           ram_we, ram_addr, ram_din
  );
endinterface

// File: rtl/vram_starve_ctr.sv
// Saturating count of consecutive refused CPU cycles; at_max forces the CPU ahead.
module vram_starve_ctr
  import vram_pkg::*;
#(
  parameter int MAX = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic at_max
);
  logic [WAIT_W-1:0] cnt_q, cnt_d;

  assign at_max = (cnt_q == WAIT_W'(MAX));

  always_comb begin
    cnt_d = cnt_q;
    if (clr)                cnt_d = '0;
    else if (inc && !at_max) cnt_d = cnt_q + WAIT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/vram_arbiter.sv
// One access per clock on VRAM port A: renderer first, CPU forced ahead after
// CPU_MAX_WAIT refusals. Read data returns one cycle later to the issuing side.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int CPU_MAX_WAIT = 8
) (
  input  logic           clk,
  input  logic           reset,
  vram_arbiter_if.slave  bus
);
  owner_t             owner_q, owner_d;
  logic [VRAM_DW-1:0] r_hold_q, r_hold_d, c_hold_q, c_hold_d;
  logic [VRAM_DW-1:0] r_rdata, c_rdata;
  logic               at_max, cpu_force, r_gnt, c_gnt, r_rvalid, c_rvalid;
  logic               ctr_inc, ctr_clr;

  assign cpu_force = bus.c_req & at_max;
  assign r_gnt     = ~reset & bus.r_req & ~cpu_force;
  assign c_gnt     = ~reset & bus.c_req & (~bus.r_req | cpu_force);
  assign ctr_inc   = bus.c_req & ~c_gnt;
  assign ctr_clr   = ~ctr_inc;

  vram_starve_ctr #(.MAX(CPU_MAX_WAIT)) u_starve (
    .clk    (clk),
    .reset  (reset),
    .inc    (ctr_inc),
    .clr    (ctr_clr),
    .at_max (at_max)
  );

  always_comb begin
    bus.ram_we   = 1'b0;
    bus.ram_addr = '0;
    bus.ram_din  = '0;
    if (c_gnt) begin
      bus.ram_we   = bus.c_we;
      bus.ram_addr = bus.c_addr;
      bus.ram_din  = bus.c_wdata;
    end else if (r_gnt) begin
      bus.ram_addr = bus.r_addr;
    end
  end

  always_comb begin
    owner_d = OWN_NONE;
    if (r_gnt)                  owner_d = OWN_REND;
    else if (c_gnt && !bus.c_we) owner_d = OWN_CPU;
  end

  // Gating with reset drops a read whose data lands in a reset cycle.
  assign r_rvalid = (owner_q == OWN_REND) & ~reset;
  assign c_rvalid = (owner_q == OWN_CPU)  & ~reset;
  assign r_rdata  = r_rvalid ? bus.ram_dout : r_hold_q;
  assign c_rdata  = c_rvalid ? bus.ram_dout : c_hold_q;
  assign r_hold_d = r_rdata;
  assign c_hold_d = c_rdata;

  assign bus.r_gnt    = r_gnt;
  assign bus.c_gnt    = c_gnt;
  assign bus.r_rvalid = r_rvalid;
  assign bus.c_rvalid = c_rvalid;
  assign bus.r_rdata  = r_rdata;
  assign bus.c_rdata  = c_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q  <= OWN_NONE;
      r_hold_q <= '0;
      c_hold_q <= '0;
    end else begin
      owner_q  <= owner_d;
      r_hold_q <= r_hold_d;
      c_hold_q <= c_hold_d;
    end
  end
endmodule
